uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver. It replaces the single-sample 8-bit receiver in the bring-up UART path. It synchronises the asynchronous serial line and times each bit from a per-bit clock count. It checks start, parity and stop bits, then delivers each frame through a one-entry valid/ready holding register to the bus-side logic.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; must be at least 4. Mid-bit point is CLKS_PER_BIT/2, truncated.
DATA_BITS, 8, data bits per frame, range 5..9, sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
en  in  1  receiver enable.
rx  in  1  asynchronous serial line; idle level is high.
data  out  DATA_BITS  received word; valid only while valid=1.
valid  out  1  holding register contains a frame.
ready  in  1  consumer accepts the frame; the transfer happens on a clk edge where valid and ready are both 1.
frame_err  out  1  travels with data: a stop bit was sampled low.
parity_err  out  1  travels with data: parity mismatch. Always 0 when PARITY=0.
overrun  out  1  one-cycle pulse: a completed frame was dropped because the holding register was still full.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (next clk edge after rst=1): data=0, valid=0, frame_err=0, parity_err=0, overrun=0. FSM goes to IDLE, counters are cleared, synchronizer flops are set to 1. Reset mid-frame aborts the frame with no output.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 cycles of latency.
- The bit counter counts from 0 to CLKS_PER_BIT-1 and wraps. Samples are taken when the counter equals CLKS_PER_BIT/2.
- FSM states:
  - IDLE: on rx_s=0 and en=1, clear the counter and go to START.
  - START: at the mid-point, rx_s=0 goes to DATA. rx_s=1 is a false start (glitch): go to IDLE and output nothing.
  - DATA: at each mid-point, shift rx_s into the MSB of the shift register, shifting right. After DATA_BITS samples, go to PARITY if PARITY!=0, otherwise to STOP.
  - PARITY: at the mid-point, compare rx_s with the computed parity. Odd parity means data bits plus parity bit have odd weight. Go to STOP.
  - STOP: sample at each mid-point. Any low stop bit sets the frame error flag. After STOP_BITS samples, go to DELIVER.
  - DELIVER (one cycle): if valid=0, or valid=1 and ready=1 in this same cycle, load data and the flags and set valid=1. Otherwise drop the frame and pulse overrun. Then go to IDLE if the frame error flag is 0, else go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This stops a held-low line from producing repeated frames.
- Latency: valid rises 2 clk edges after the mid-sample of the final stop bit (DELIVER cycle, then register load).
- Frames with errors are still delivered, with their flags set.
- Handshake: valid stays high and data/flags stay stable until accepted. On acceptance with no new load in the same cycle, valid goes to 0 on that edge. A load and an acceptance in the same cycle leave valid=1 with the new data.
- en=0: the FSM returns to IDLE on the next edge and any frame in progress is discarded. The holding register, valid and the handshake are unaffected. en is ignored mid-bit only in the sense that abort takes priority over sampling.
- Bit counter width: clog2(CLKS_PER_BIT). Data-bit counter width: clog2(DATA_BITS+1).

Decomposition:
- Package uart_pkg:
  - state encoding enum: IDLE, START, DATA, PARITY, STOP, DELIVER, BREAK;
  - parity mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - a parity function over a DATA_BITS vector.
- One sub-module, uart_sync2: 2-flop synchronizer with reset value 1. It is shared with the future transmitter's CTS input.

Test Plan:
- Defaults (16/8/none/1): send 0xA5, ready held 1 -> data=0xA5, valid high for exactly 1 cycle, frame_err=0, parity_err=0.
- DATA_BITS=7, PARITY=2 (even): send 0x35 with correct parity bit 0 -> parity_err=0. Resend with parity bit flipped -> data=0x35, parity_err=1.
- Stop bit forced low on 0x3C -> data=0x3C, frame_err=1. Hold rx low for 40 bit times -> no further valid until rx returns high and a new start bit is sent.
- Glitch: rx low for 5 clks only -> no valid, FSM back in IDLE. A following 0x0F frame is received correctly.
- ready=0: send 0x11 then 0x22 -> data stays 0x11, overrun pulses 1 cycle at the end of 0x22. Raise ready -> valid drops and 0x22 is never presented.
- Assert rst during the DATA state of 0xFF -> all outputs are 0 on the next edge. A subsequent 0x81 frame is received correctly. Repeat with en=0 mid-frame -> same abort, and the pending holding-register contents are preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity modes and parity helper for the UART receive path
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DELIVER,
        ST_BREAK
    } rx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for the low nbits of d; words narrower than
    // MAX_DATA_BITS are zero-extended by the caller.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] d,
                                         input int nbits,
                                         input int mode);
        logic x;
        x = 1'b0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < nbits) begin
                x = x ^ d[i];
            end
        end
        return (mode == PAR_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// rtl/uart_rx_os_if.sv - valid/ready delivery bus from the UART receiver to bus-side logic
interface uart_rx_os_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        output data, valid, frame_err, parity_err, overrun,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, parity_err, overrun,
        output ready
    );
endinterface

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for asynchronous line inputs, resets to 1
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampling UART receiver with start/parity/stop checks and a one-entry holding register
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          rx_i,
    uart_rx_os_if.master  rx_bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_s)
    );

    rx_state_e            state_q,      state_d;
    logic [CW-1:0]        cnt_q,        cnt_d;
    logic [BW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 ferr_q,       ferr_d;
    logic                 perr_q,       perr_d;
    logic [DATA_BITS-1:0] data_q,       data_d;
    logic                 valid_q,      valid_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q,    overrun_d;

    logic mid;
    assign mid = (cnt_q == CNT_MID);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ferr_d       = ferr_q;
        perr_d       = perr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;

        if (valid_q && rx_bus.ready) begin
            valid_d = 1'b0;
        end

        if (state_q != ST_IDLE) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end

        // Disable wins over any sampling decision in flight.
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        ferr_d    = 1'b0;
                        perr_d    = 1'b0;
                        state_d   = ST_START;
                    end
                end
                ST_START: begin
                    if (mid) begin
                        bit_cnt_d = '0;
                        state_d   = rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mid) begin
                        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (mid) begin
                        perr_d  = (rx_s != calc_parity(MAX_DATA_BITS'(shift_q), DATA_BITS, PARITY));
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (mid) begin
                        if (!rx_s) begin
                            ferr_d = 1'b1;
                        end
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == STOP_LAST) begin
                            state_d = ST_DELIVER;
                        end
                    end
                end
                ST_DELIVER: begin
                    if (!valid_q || rx_bus.ready) begin
                        data_d       = shift_q;
                        frame_err_d  = ferr_q;
                        parity_err_d = perr_q;
                        valid_d      = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    // A low stop bit usually means a held-low line; wait for idle before rearming.
                    state_d = ferr_q ? ST_BREAK : ST_IDLE;
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_bus.data       = data_q;
    assign rx_bus.valid      = valid_q;
    assign rx_bus.frame_err  = frame_err_q;
    assign rx_bus.parity_err = parity_err_q;
    assign rx_bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - directed self-checking bench for uart_rx_os (8N1 and 7E1 instances)
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic en;
    logic rx0;
    logic rx1;

    uart_rx_os_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_os_if #(.DATA_BITS(7)) bus1 ();

    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .rx_i   (rx0),
        .rx_bus (bus0.master)
    );

    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en),
        .rx_i   (rx1),
        .rx_bus (bus1.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observation counters, sampled on the falling edge.
    int         vcnt0 = 0, ovcnt0 = 0, seen22 = 0;
    int         vcnt1 = 0;
    logic [7:0] cap_data0 = '0;
    logic       cap_fe0 = 1'b0, cap_pe0 = 1'b0;
    logic [6:0] cap_data1 = '0;
    logic       cap_fe1 = 1'b0, cap_pe1 = 1'b0;

    always @(negedge clk) begin
        if (bus0.valid === 1'b1) begin
            vcnt0++;
            cap_data0 = bus0.data;
            cap_fe0   = bus0.frame_err;
            cap_pe0   = bus0.parity_err;
            if (bus0.data == 8'h22) seen22++;
        end
        if (bus0.overrun === 1'b1) ovcnt0++;
        if (bus1.valid === 1'b1) begin
            vcnt1++;
            cap_data1 = bus1.data;
            cap_fe1   = bus1.frame_err;
            cap_pe1   = bus1.parity_err;
        end
    end

    task automatic drive_bit(input int sel, input logic lvl);
        if (sel == 0) rx0 = lvl;
        else          rx1 = lvl;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits,
                              input int par, input logic stop_lvl);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i]);
        if (par >= 0) drive_bit(sel, par[0]);
        drive_bit(sel, stop_lvl);
    endtask

    task automatic send_ok(input int sel, input logic [8:0] d, input int nbits, input int par);
        send_frame(sel, d, nbits, par, 1'b1);
        drive_bit(sel, 1'b1);
    endtask

    int base, obase, sbase;

    initial begin
        rst = 1'b1; en = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
        bus0.ready = 1'b1; bus1.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid0", bus0.valid, 0);
        check_eq("rst_data0", bus0.data, 0);
        check_eq("rst_ferr0", bus0.frame_err, 0);
        check_eq("rst_perr0", bus0.parity_err, 0);
        check_eq("rst_ovr0", bus0.overrun, 0);
        check_eq("rst_valid1", bus1.valid, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 basic frame, ready held high
        base = vcnt0;
        send_ok(0, 9'h0A5, 8, -1);
        check_eq("a5_vcycles", vcnt0 - base, 1);
        check_eq("a5_data", cap_data0, 8'hA5);
        check_eq("a5_ferr", cap_fe0, 0);
        check_eq("a5_perr", cap_pe0, 0);

        // 7E1: 0x35 has four ones, so the even parity bit is 0
        base = vcnt1;
        send_ok(1, 9'h035, 7, 0);
        check_eq("p_ok_vcycles", vcnt1 - base, 1);
        check_eq("p_ok_data", cap_data1, 7'h35);
        check_eq("p_ok_perr", cap_pe1, 0);
        base = vcnt1;
        send_ok(1, 9'h035, 7, 1);
        check_eq("p_bad_vcycles", vcnt1 - base, 1);
        check_eq("p_bad_data", cap_data1, 7'h35);
        check_eq("p_bad_perr", cap_pe1, 1);
        check_eq("p_bad_ferr", cap_fe1, 0);

        // Low stop bit, then line held low for 40 bit times
        base = vcnt0;
        send_frame(0, 9'h03C, 8, -1, 1'b0);
        for (int i = 0; i < 40; i++) drive_bit(0, 1'b0);
        check_eq("brk_vcycles", vcnt0 - base, 1);
        check_eq("brk_data", cap_data0, 8'h3C);
        check_eq("brk_ferr", cap_fe0, 1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        base = vcnt0;
        send_ok(0, 9'h066, 8, -1);
        check_eq("post_brk_vcycles", vcnt0 - base, 1);
        check_eq("post_brk_data", cap_data0, 8'h66);
        check_eq("post_brk_ferr", cap_fe0, 0);

        // 5-clock glitch must not start a frame
        base = vcnt0;
        @(negedge clk) rx0 = 1'b0;
        repeat (5) @(negedge clk);
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("glitch_vcycles", vcnt0 - base, 0);
        check_eq("glitch_idle", 32'(dut0.state_q), 32'(ST_IDLE));
        base = vcnt0;
        send_ok(0, 9'h00F, 8, -1);
        check_eq("post_glitch_vcycles", vcnt0 - base, 1);
        check_eq("post_glitch_data", cap_data0, 8'h0F);

        // Overrun with consumer stalled
        @(negedge clk) bus0.ready = 1'b0;
        obase = ovcnt0;
        sbase = seen22;
        send_ok(0, 9'h011, 8, -1);
        send_ok(0, 9'h022, 8, -1);
        check_eq("ovr_valid", bus0.valid, 1);
        check_eq("ovr_data", bus0.data, 8'h11);
        check_eq("ovr_pulses", ovcnt0 - obase, 1);
        @(negedge clk) bus0.ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_drop_valid", bus0.valid, 0);
        repeat (CPB) @(negedge clk);
        check_eq("ovr_no_22", seen22 - sbase, 0);

        // Reset during the data bits of 0xFF with a frame pending
        bus0.ready = 1'b0;
        send_ok(0, 9'h033, 8, -1);
        check_eq("pend33_data", bus0.data, 8'h33);
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_valid", bus0.valid, 0);
        check_eq("rst_mid_data", bus0.data, 0);
        check_eq("rst_mid_ferr", bus0.frame_err, 0);
        check_eq("rst_mid_perr", bus0.parity_err, 0);
        check_eq("rst_mid_ovr", bus0.overrun, 0);
        rst = 1'b0;
        bus0.ready = 1'b1;
        base = vcnt0;
        for (int i = 0; i < 7; i++) drive_bit(0, 1'b1);
        check_eq("rst_abort_vcycles", vcnt0 - base, 0);
        base = vcnt0;
        send_ok(0, 9'h081, 8, -1);
        check_eq("post_rst_vcycles", vcnt0 - base, 1);
        check_eq("post_rst_data", cap_data0, 8'h81);

        // Disable during the data bits of 0xFF with a frame pending
        @(negedge clk) bus0.ready = 1'b0;
        send_ok(0, 9'h044, 8, -1);
        obase = ovcnt0;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        @(negedge clk) en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 8; i++) drive_bit(0, 1'b1);
        check_eq("en_abort_ovr", ovcnt0 - obase, 0);
        check_eq("en_keep_valid", bus0.valid, 1);
        check_eq("en_keep_data", bus0.data, 8'h44);
        @(negedge clk) bus0.ready = 1'b1;
        @(negedge clk);
        check_eq("en_accept_valid", bus0.valid, 0);
        base = vcnt0;
        send_ok(0, 9'h081, 8, -1);
        check_eq("post_en_vcycles", vcnt0 - base, 1);
        check_eq("post_en_data", cap_data0, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
